// File: rtl/display_7seg_scan_pkg.sv
// ----------------------------------------------------------------------------
// display_7seg_scan_pkg
//   Shared types and constants for the 4-digit 7-segment scanner.
//   - SEG_0 .. SEG_F : active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   - SEG_OFF/AN_OFF : all segments / all anodes dark
//   - digit_idx_t    : which of the four digits is being scanned
//   - frame_t        : one latched frame of display content
//   - next_digit     : scan order 0->1->2->3->0
//   - lz_blank_mask  : which digits are suppressed as leading zeros
// ----------------------------------------------------------------------------
package display_7seg_scan_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    typedef enum logic [1:0] {
        DIGIT_0 = 2'd0,
        DIGIT_1 = 2'd1,
        DIGIT_2 = 2'd2,
        DIGIT_3 = 2'd3
    } digit_idx_t;

    // digits[i] holds digit i (digit 0 is the rightmost one)
    typedef struct packed {
        logic [3:0][3:0] digits;
        logic [3:0]      dp;
        logic            lz_en;
    } frame_t;

    function automatic digit_idx_t next_digit(input digit_idx_t d);
        return digit_idx_t'(d + 2'd1);
    endfunction

    // Walk from the leftmost digit towards the right; a digit stays in the
    // "leading" run only while it and every digit to its left are zero with
    // no decimal point requested. Digit 0 always stays visible so a value of
    // zero still shows a single 0.
    function automatic logic [3:0] lz_blank_mask(
        input logic [3:0][3:0] digits,
        input logic [3:0]      dp,
        input logic            lz_en
    );
        logic [3:0] mask;
        logic       leading;
        mask    = '0;
        leading = lz_en;
        for (int i = 3; i >= 1; i--) begin
            leading = leading && (digits[i] == 4'd0) && !dp[i];
            mask[i] = leading;
        end
        return mask;
    endfunction

endpackage

// File: rtl/display_7seg_scan_if.sv
// ----------------------------------------------------------------------------
// display_7seg_scan_if
//   Bundle between the digit-select mux (master) and the scanner (slave).
//   Master drives : in_0..in_3 (digit nibbles), dp_sel, lz_en, disp_en
//   Slave drives  : an (active-low anodes), seg (active-low {g..a}),
//                   dp (active-low), frame_tick (new frame latched)
// ----------------------------------------------------------------------------
interface display_7seg_scan_if;

    logic [3:0] in_0;
    logic [3:0] in_1;
    logic [3:0] in_2;
    logic [3:0] in_3;
    logic [3:0] dp_sel;
    logic       lz_en;
    logic       disp_en;

    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    modport master (
        output in_0, in_1, in_2, in_3, dp_sel, lz_en, disp_en,
        input  an, seg, dp, frame_tick
    );

    modport slave (
        input  in_0, in_1, in_2, in_3, dp_sel, lz_en, disp_en,
        output an, seg, dp, frame_tick
    );

endinterface

// File: rtl/display_7seg_scan_hex_to_7seg.sv
// ----------------------------------------------------------------------------
// hex_to_7seg
//   Combinational hex nibble to active-low 7-segment pattern.
//   hex : 4-bit value 0..F
//   seg : segments {g,f,e,d,c,b,a}, 0 = lit
// ----------------------------------------------------------------------------
module hex_to_7seg
    import display_7seg_scan_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Lower-case b and d are used so they cannot be confused with 8 and 0.
    always_comb begin
        seg = SEG_OFF;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/display_7seg_scan.sv
// ----------------------------------------------------------------------------
// display_7seg_scan
//   Time-multiplexed driver for a 4-digit common-anode 7-segment display.
//   Each digit owns a slot of REFRESH_DIV clocks; the first BLANK_CYC clocks
//   of every slot are dark so the previous digit's segments do not ghost onto
//   the next anode. Inputs are latched once per frame (after digit 3) so a
//   changing value never tears across digits.
//
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of display_7seg_scan_if
//              in_0..in_3, dp_sel, lz_en, disp_en  -> inputs
//              an, seg, dp, frame_tick             <- registered outputs
// ----------------------------------------------------------------------------
module display_7seg_scan
    import display_7seg_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
)
(
    input  logic                clk,
    input  logic                reset_n,
    display_7seg_scan_if.slave  bus
);

    localparam int              CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt;
    digit_idx_t       idx;
    frame_t           shadow;

    logic             slot_end;
    logic             frame_end;
    logic             in_blank_window;
    logic [3:0]       blank_mask;
    logic [3:0]       cur_digit;
    logic [6:0]       cur_seg;
    logic             dark;

    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic             dp_q;
    logic             frame_tick_q;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == DIGIT_3);

    // Slot prescaler and digit index. The index steps exactly once per slot,
    // in lock-step with the prescaler wrap, and ignores disp_en so the frame
    // cadence stays fixed while the display is dark.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            idx <= DIGIT_0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= next_digit(idx);
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frame latch: the shadow copy is only refreshed as digit 3's slot ends,
    // so all four digits of a frame always come from the same input snapshot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow       <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            frame_tick_q <= frame_end;
            if (frame_end) begin
                shadow.digits <= {bus.in_3, bus.in_2, bus.in_1, bus.in_0};
                shadow.dp     <= bus.dp_sel;
                shadow.lz_en  <= bus.lz_en;
            end
        end
    end

    // A zero-length blank window would make the compare trivially false, so
    // it is removed entirely in that case.
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign in_blank_window = 1'b0;
        end else begin : g_blank
            assign in_blank_window = (cnt < CNT_W'(BLANK_CYC));
        end
    endgenerate

    assign blank_mask = lz_blank_mask(shadow.digits, shadow.dp, shadow.lz_en);
    assign cur_digit  = shadow.digits[idx];
    assign dark       = !bus.disp_en || in_blank_window || blank_mask[idx];

    hex_to_7seg u_hex_to_7seg (
        .hex (cur_digit),
        .seg (cur_seg)
    );

    // Pin registers: everything the board sees comes straight from a flop so
    // the anode and segment lines switch together without combinational
    // glitches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
        end else if (dark) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= ~(4'b0001 << idx);
            seg_q <= cur_seg;
            dp_q  <= ~shadow.dp[idx];
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_7seg_scan.sv
// ----------------------------------------------------------------------------
// tb_display_7seg_scan
//   Self-checking bench for display_7seg_scan with REFRESH_DIV=8, BLANK_CYC=2.
//   The reference model derives the expected pins from the number of clock
//   edges since reset: edge s shows slot position s%8 of digit (s/8)%4, and
//   a new input snapshot is taken on every edge where s%32 == 31.
// ----------------------------------------------------------------------------
module tb_display_7seg_scan;

    localparam int REFRESH_DIV = 8;
    localparam int BLANK_CYC   = 2;
    localparam int FRAME_LEN   = 4 * REFRESH_DIV;

    localparam logic [6:0] SEG_REF [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic clk;
    logic reset_n;

    display_7seg_scan_if bus ();

    display_7seg_scan #(
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYC   (BLANK_CYC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int          cyc;
    logic [15:0] m_digs;
    logic [3:0]  m_dp;
    logic        m_lz;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_tick;

    // Expected {an, seg, dp} for the edge numbered s. Leading-zero blanking
    // is expressed as "every digit left of the most significant digit that
    // is nonzero or carries a decimal point goes dark".
    function automatic logic [11:0] model_out(input int s, input logic [15:0] digs,
                                              input logic [3:0] dps, input logic lz,
                                              input logic en);
        int         pos;
        int         digit;
        int         keep;
        logic [3:0] onehot;
        logic [3:0] d;
        pos   = s % REFRESH_DIV;
        digit = (s / REFRESH_DIV) % 4;
        keep  = 0;
        for (int i = 0; i < 4; i++) begin
            if (digs[i*4 +: 4] != 4'd0 || dps[i]) keep = i;
        end
        if (!en || pos < BLANK_CYC || (lz && digit > keep))
            return {4'b1111, 7'b1111111, 1'b1};
        onehot = 4'b0001 << digit;
        d      = digs[digit*4 +: 4];
        return {~onehot, SEG_REF[d], ~dps[digit]};
    endfunction

    // Reference model, advanced on the same edges as the DUT.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc      <= 0;
            m_digs   <= '0;
            m_dp     <= '0;
            m_lz     <= 1'b0;
            exp_an   <= 4'b1111;
            exp_seg  <= 7'b1111111;
            exp_dp   <= 1'b1;
            exp_tick <= 1'b0;
        end else begin
            {exp_an, exp_seg, exp_dp} <= model_out(cyc, m_digs, m_dp, m_lz, bus.disp_en);
            exp_tick <= (cyc % FRAME_LEN == FRAME_LEN - 1);
            if (cyc % FRAME_LEN == FRAME_LEN - 1) begin
                m_digs <= {bus.in_3, bus.in_2, bus.in_1, bus.in_0};
                m_dp   <= bus.dp_sel;
                m_lz   <= bus.lz_en;
            end
            cyc <= cyc + 1;
        end
    end

    task automatic applyStimulus(input logic [3:0] d0, input logic [3:0] d1,
                                 input logic [3:0] d2, input logic [3:0] d3,
                                 input logic [3:0] dps, input logic lz, input logic en);
        bus.in_0    = d0;
        bus.in_1    = d1;
        bus.in_2    = d2;
        bus.in_3    = d3;
        bus.dp_sel  = dps;
        bus.lz_en   = lz;
        bus.disp_en = en;
    endtask

    task automatic checkOutput(input string tag);
        checks++;
        assert (bus.an === exp_an) else begin
            failures++;
            $error("[TB] FAIL %s an got=%b exp=%b t=%0t", tag, bus.an, exp_an, $time);
        end
        checks++;
        assert (bus.seg === exp_seg) else begin
            failures++;
            $error("[TB] FAIL %s seg got=%b exp=%b t=%0t", tag, bus.seg, exp_seg, $time);
        end
        checks++;
        assert (bus.dp === exp_dp) else begin
            failures++;
            $error("[TB] FAIL %s dp got=%b exp=%b t=%0t", tag, bus.dp, exp_dp, $time);
        end
        checks++;
        assert (bus.frame_tick === exp_tick) else begin
            failures++;
            $error("[TB] FAIL %s frame_tick got=%b exp=%b t=%0t", tag, bus.frame_tick, exp_tick, $time);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checks++;
        assert (bus.an === 4'b1111) else begin
            failures++;
            $error("[TB] FAIL %s an got=%b exp=1111", tag, bus.an);
        end
        checks++;
        assert (bus.seg === 7'b1111111) else begin
            failures++;
            $error("[TB] FAIL %s seg got=%b exp=1111111", tag, bus.seg);
        end
        checks++;
        assert (bus.dp === 1'b1) else begin
            failures++;
            $error("[TB] FAIL %s dp got=%b exp=1", tag, bus.dp);
        end
        checks++;
        assert (bus.frame_tick === 1'b0) else begin
            failures++;
            $error("[TB] FAIL %s frame_tick got=%b exp=0", tag, bus.frame_tick);
        end
    endtask

    task automatic run_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput(tag);
        end
    endtask

    // Runs (checking every cycle) until the DUT pulses frame_tick, with a
    // bound of two frames; a missing pulse is itself a failed comparison.
    task automatic wait_frame(input string tag);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 2 * FRAME_LEN) begin
            @(negedge clk);
            checkOutput(tag);
            if (bus.frame_tick === 1'b1) seen = 1'b1;
            n++;
        end
        checks++;
        assert (seen === 1'b1) else begin
            failures++;
            $error("[TB] FAIL %s frame_tick got=none exp=pulse within %0d cycles", tag, 2 * FRAME_LEN);
        end
    endtask

    initial begin
        reset_n = 1'b1;
        applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b0, 1'b1);
        #2 reset_n = 1'b0;
        run_cycles(3, "reset_idle");
        checkResetOutputs("reset_idle_const");
        reset_n = 1'b1;

        $display("[TB] scan order");
        applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0, 1'b1);
        wait_frame("scan_first_frame");
        run_cycles(2 * FRAME_LEN, "scan_order");
        run_cycles(13, "scan_mid");

        $display("[TB] reset mid-scan");
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 checkResetOutputs("reset_async");
        @(negedge clk);
        checkOutput("reset_hold");
        reset_n = 1'b1;
        wait_frame("reset_zero_frame");
        run_cycles(FRAME_LEN - 1, "reset_recover");

        $display("[TB] frame latch");
        wait_frame("latch_sync");
        run_cycles(REFRESH_DIV + 2, "latch_idx1");
        applyStimulus(4'd9, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0, 1'b1);
        wait_frame("latch_old");
        wait_frame("latch_new");

        $display("[TB] leading-zero blanking");
        applyStimulus(4'd0, 4'd5, 4'd0, 4'd0, 4'b0000, 1'b1, 1'b1);
        wait_frame("lz_latch");
        wait_frame("lz_show");
        applyStimulus(4'd0, 4'd5, 4'd0, 4'd0, 4'b0100, 1'b1, 1'b1);
        wait_frame("lz_dp_latch");
        wait_frame("lz_dp_show");
        applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1, 1'b1);
        wait_frame("lz_all_zero_latch");
        wait_frame("lz_all_zero_show");

        $display("[TB] hex sweep");
        for (int v = 0; v < 16; v++) begin
            applyStimulus(4'(v), 4'(15 - v), 4'((v + 3) % 16), 4'((v + 7) % 16),
                          4'(v % 16), 1'b0, 1'b1);
            wait_frame("hex_sweep");
        end
        wait_frame("hex_sweep_last");

        $display("[TB] display disable");
        run_cycles(5, "dis_pre");
        applyStimulus(4'd8, 4'd8, 4'd8, 4'd8, 4'b1111, 1'b0, 1'b0);
        run_cycles(20, "dis_dark");
        bus.disp_en = 1'b1;
        wait_frame("dis_resume");
        wait_frame("dis_period");

        $display("[TB] random frames");
        for (int r = 0; r < 24; r++) begin
            logic [3:0] rd [4];
            for (int k = 0; k < 4; k++)
                rd[k] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            applyStimulus(rd[0], rd[1], rd[2], rd[3],
                          ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 7) != 0));
            run_cycles(int'($urandom_range(5, 45)), "random");
        end
        wait_frame("random_tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
